// File: rtl/ddr2_init_engine.sv
// DDR2 power-up initialization sequencer: walks CKE and the command bus through the JEDEC init steps, then raises ready.
// Optional macro DDR2_INIT_FAST_SIM_EN shortens the CKE-low and DLL-lock waits to 16 cycles for simulation.
module ddr2_init_engine #(
  parameter logic [2:0]  BL     = 3'b011,
  parameter logic        BT     = 1'b0,
  parameter logic [2:0]  CL     = 3'b011,
  parameter logic [2:0]  AL     = 3'b001,
  parameter logic [2:0]  WR     = 3'b010,
  parameter int unsigned T_INIT = 40000,
  parameter int unsigned T_XPR  = 80,
  parameter int unsigned T_RP   = 3,
  parameter int unsigned T_MRD  = 2,
  parameter int unsigned T_RFC  = 21,
  parameter int unsigned T_DLL  = 200
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ready,
  output logic        busy,
  output logic        cke,
  output logic        cs_bar,
  output logic        ras_bar,
  output logic        cas_bar,
  output logic        we_bar,
  output logic [1:0]  BA,
  output logic [12:0] A,
  output logic        ODT,
  output logic [3:0]  init_state
);
`ifdef DDR2_INIT_FAST_SIM_EN
  localparam int unsigned INIT_CYC = 16;
  localparam int unsigned DLL_CYC  = 16;
`else
  localparam int unsigned INIT_CYC = T_INIT;
  localparam int unsigned DLL_CYC  = T_DLL;
`endif

  localparam logic [3:0] S_CKE_WAIT  = 4'd0;
  localparam logic [3:0] S_XPR       = 4'd1;
  localparam logic [3:0] S_PRE1      = 4'd2;
  localparam logic [3:0] S_EMRS2     = 4'd3;
  localparam logic [3:0] S_EMRS3     = 4'd4;
  localparam logic [3:0] S_EMRS1_DLL = 4'd5;
  localparam logic [3:0] S_MRS_RST   = 4'd6;
  localparam logic [3:0] S_PRE2      = 4'd7;
  localparam logic [3:0] S_REF1      = 4'd8;
  localparam logic [3:0] S_REF2      = 4'd9;
  localparam logic [3:0] S_MRS       = 4'd10;
  localparam logic [3:0] S_DLL_WAIT  = 4'd11;
  localparam logic [3:0] S_OCD_DEF   = 4'd12;
  localparam logic [3:0] S_OCD_EXIT  = 4'd13;
  localparam logic [3:0] S_DONE      = 4'd14;

  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_LMR = 4'b0000;

  localparam logic [12:0] MRS_BASE  = {1'b0, WR, 1'b0, 1'b0, CL, BT, BL};
  localparam logic [12:0] EMRS_BASE = {3'b000, 3'b000, 1'b0, AL, 1'b1, 1'b0, 1'b0};
  localparam logic [12:0] DLL_RST   = 13'h0100;
  localparam logic [12:0] OCD_DFLT  = 13'h0380;
  localparam logic [12:0] A10       = 13'h0400;

  // A slot of 0 or 1 still takes one cycle (the command itself).
  function automatic logic [15:0] last_of(input int unsigned slot);
    return (slot <= 1) ? 16'd0 : 16'(slot - 1);
  endfunction

  logic [3:0]  state, nxt_state;
  logic [15:0] cnt, nxt_cnt, slot_last;
  logic [3:0]  cmd_q, cmd_d;
  logic [1:0]  ba_d;
  logic [12:0] a_d;

  always_comb begin
    slot_last = 16'd0;
    case (state)
      S_CKE_WAIT:                                        slot_last = last_of(INIT_CYC);
      S_XPR:                                             slot_last = last_of(T_XPR);
      S_PRE1, S_PRE2:                                    slot_last = last_of(T_RP);
      S_REF1, S_REF2:                                    slot_last = last_of(T_RFC);
      S_DLL_WAIT:                                        slot_last = last_of(DLL_CYC);
      S_EMRS2, S_EMRS3, S_EMRS1_DLL, S_MRS_RST, S_MRS,
      S_OCD_DEF, S_OCD_EXIT:                             slot_last = last_of(T_MRD);
      default:                                           slot_last = 16'd0;
    endcase
  end

  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt + 16'd1;
    if (state == S_DONE) begin
      nxt_cnt = 16'd0;
    end else if (cnt == slot_last) begin
      nxt_state = state + 4'd1;
      nxt_cnt   = 16'd0;
    end
  end

  // Outputs are decoded from the next state so the registered bus lines up with init_state.
  always_comb begin
    cmd_d = CMD_NOP;
    ba_d  = 2'b00;
    a_d   = 13'h0000;
    if (nxt_cnt == 16'd0) begin
      case (nxt_state)
        S_PRE1, S_PRE2: begin cmd_d = CMD_PRE; a_d = A10; end
        S_EMRS2:        begin cmd_d = CMD_LMR; ba_d = 2'b10; end
        S_EMRS3:        begin cmd_d = CMD_LMR; ba_d = 2'b11; end
        S_EMRS1_DLL:    begin cmd_d = CMD_LMR; ba_d = 2'b01; a_d = EMRS_BASE; end
        S_MRS_RST:      begin cmd_d = CMD_LMR; a_d = MRS_BASE | DLL_RST; end
        S_REF1, S_REF2: cmd_d = CMD_REF;
        S_MRS:          begin cmd_d = CMD_LMR; a_d = MRS_BASE; end
        S_OCD_DEF:      begin cmd_d = CMD_LMR; ba_d = 2'b01; a_d = EMRS_BASE | OCD_DFLT; end
        S_OCD_EXIT:     begin cmd_d = CMD_LMR; ba_d = 2'b01; a_d = EMRS_BASE; end
        default:        cmd_d = CMD_NOP;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_CKE_WAIT;
      cnt   <= 16'd0;
      cke   <= 1'b0;
      cmd_q <= CMD_NOP;
      BA    <= 2'b00;
      A     <= 13'h0000;
      ready <= 1'b0;
      busy  <= 1'b1;
    end else begin
      state <= nxt_state;
      cnt   <= nxt_cnt;
      cke   <= (nxt_state != S_CKE_WAIT);
      cmd_q <= cmd_d;
      BA    <= ba_d;
      A     <= a_d;
      ready <= (nxt_state == S_DONE);
      busy  <= (nxt_state != S_DONE);
    end
  end

  assign {cs_bar, ras_bar, cas_bar, we_bar} = cmd_q;
  assign ODT        = 1'b0;
  assign init_state = state;
endmodule

// File: tb/tb_ddr2_init_engine.sv
// Bench for ddr2_init_engine: timeline model of the init sequence compared every cycle, plus literal mode-word/latency checks.
module tb_ddr2_init_engine;
`ifdef DDR2_INIT_FAST_SIM_EN
  localparam int M_INIT = 16;
  localparam int M_DLL  = 16;
  localparam int TOTAL_LIT = 174;
  localparam int DLL_GAP_LIT = 18;
`else
  localparam int M_INIT = 40000;
  localparam int M_DLL  = 200;
  localparam int TOTAL_LIT = 40342;
  localparam int DLL_GAP_LIT = 202;
`endif
  localparam int M_XPR = 80, M_RP = 3, M_MRD = 2, M_RFC = 21;
  localparam int M_WR = 2, M_CL = 3, M_BT = 0, M_BL = 3, M_AL = 1;
  localparam logic [3:0] NOP = 4'b0111, PRE = 4'b0010, REF = 4'b0001, LMR = 4'b0000;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic ready, busy, cke, cs_bar, ras_bar, cas_bar, we_bar, ODT;
  logic [1:0] BA;
  logic [12:0] A;
  logic [3:0] init_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int cke_rise = -1, ready_rise = -1, mrs_at = -1, ocd_at = -1;
  logic [18:0] cap[$];

  ddr2_init_engine dut (
    .clk(clk), .reset(reset), .ready(ready), .busy(busy), .cke(cke),
    .cs_bar(cs_bar), .ras_bar(ras_bar), .cas_bar(cas_bar), .we_bar(we_bar),
    .BA(BA), .A(A), .ODT(ODT), .init_state(init_state)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset)
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;

  function automatic int seg_len(input int i);
    case (i)
      0: return M_INIT;
      1: return M_XPR;
      2, 7: return M_RP;
      8, 9: return M_RFC;
      11: return M_DLL;
      default: return M_MRD;
    endcase
  endfunction

  function automatic int mrs_word(input int dll);
    return M_WR * 512 + dll * 256 + M_CL * 16 + M_BT * 8 + M_BL;
  endfunction

  function automatic int emrs_word(input int ocd);
    return ocd * 128 + M_AL * 8 + 4;
  endfunction

  // Expected outputs t posedges after reset release: {ready,busy,cke,cmd,BA,A,ODT,state}
  function automatic logic [26:0] model(input int t);
    int start, len, st, off, a;
    logic [3:0] cmd;
    int ba;
    st = 14; off = 0; start = 0;
    for (int i = 0; i < 14; i++) begin
      len = seg_len(i);
      if (len < 1) len = 1;
      if (t >= start && t < start + len) begin st = i; off = t - start; end
      start += len;
    end
    cmd = NOP; ba = 0; a = 0;
    if (st < 14 && off == 0) begin
      case (st)
        2, 7:  begin cmd = PRE; a = 1024; end
        3:     begin cmd = LMR; ba = 2; end
        4:     begin cmd = LMR; ba = 3; end
        5:     begin cmd = LMR; ba = 1; a = emrs_word(0); end
        6:     begin cmd = LMR; a = mrs_word(1); end
        8, 9:  cmd = REF;
        10:    begin cmd = LMR; a = mrs_word(0); end
        12:    begin cmd = LMR; ba = 1; a = emrs_word(7); end
        13:    begin cmd = LMR; ba = 1; a = emrs_word(0); end
        default: cmd = NOP;
      endcase
    end
    return {st == 14, st != 14, st != 0, cmd, 2'(ba), 13'(a), 1'b0, 4'(st)};
  endfunction

  always @(negedge clk) begin
    logic [26:0] exp_v, act_v;
    exp_v = model(cyc);
    act_v = {ready, busy, cke, cs_bar, ras_bar, cas_bar, we_bar, BA, A, ODT, init_state};
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL cycle_model t=%0d got %h expected %h", cyc, act_v, exp_v);
    end
    if (reset) begin
      if ({cs_bar, ras_bar, cas_bar, we_bar} != NOP) begin
        cap.push_back({cs_bar, ras_bar, cas_bar, we_bar, BA, A});
        if ({cs_bar, ras_bar, cas_bar, we_bar} == LMR && BA == 2'b00 && A[8] == 1'b0) mrs_at = cyc;
        if ({cs_bar, ras_bar, cas_bar, we_bar} == LMR && A[9:7] == 3'b111) ocd_at = cyc;
      end
      if (cke === 1'b1 && cke_rise < 0) cke_rise = cyc;
      if (ready === 1'b1 && ready_rise < 0) ready_rise = cyc;
    end
  end

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp_v, exp_v);
    end
  endtask

  logic [18:0] exp_cmds [11];
  initial begin
    exp_cmds[0]  = {PRE, 2'b00, 13'h0400};
    exp_cmds[1]  = {LMR, 2'b10, 13'h0000};
    exp_cmds[2]  = {LMR, 2'b11, 13'h0000};
    exp_cmds[3]  = {LMR, 2'b01, 13'h000C};
    exp_cmds[4]  = {LMR, 2'b00, 13'h0533};
    exp_cmds[5]  = {PRE, 2'b00, 13'h0400};
    exp_cmds[6]  = {REF, 2'b00, 13'h0000};
    exp_cmds[7]  = {REF, 2'b00, 13'h0000};
    exp_cmds[8]  = {LMR, 2'b00, 13'h0433};
    exp_cmds[9]  = {LMR, 2'b01, 13'h038C};
    exp_cmds[10] = {LMR, 2'b01, 13'h000C};

    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_cke", int'(cke), 0);
    chk("reset_ready_busy", int'({ready, busy}), 1);
    chk("reset_cmd", int'({cs_bar, ras_bar, cas_bar, we_bar}), 7);
    reset = 1'b1;

    // Run into the middle of the first REFRESH slot, then abort asynchronously.
    repeat (M_INIT + M_XPR + 2 * M_RP + 4 * M_MRD + 10) @(negedge clk);
    chk("pre_abort_state", int'(init_state), 8);
    #2 reset = 1'b0;
    #1;
    chk("abort_cke", int'(cke), 0);
    chk("abort_ready", int'(ready), 0);
    chk("abort_cmd", int'({cs_bar, ras_bar, cas_bar, we_bar}), 7);
    chk("abort_state", int'(init_state), 0);
    cap.delete();
    cke_rise = -1; ready_rise = -1; mrs_at = -1; ocd_at = -1;
    repeat (3) @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < TOTAL_LIT + 20 && ready_rise < 0; i++) @(negedge clk);
    if (ready_rise < 0) begin
      errors++;
      $display("FAIL ready_timeout got none expected %0d", TOTAL_LIT);
    end
    chk("ready_latency", ready_rise, TOTAL_LIT);
    chk("cke_rise", cke_rise, M_INIT);
    chk("dll_gap", ocd_at - mrs_at, DLL_GAP_LIT);
    chk("cmd_count", cap.size(), 11);
    for (int i = 0; i < 11; i++)
      if (i < cap.size()) chk($sformatf("cmd_%0d", i), int'(cap[i]), int'(exp_cmds[i]));

    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (ready !== 1'b1 || cke !== 1'b1 || ODT !== 1'b0 ||
          {cs_bar, ras_bar, cas_bar, we_bar} !== NOP) begin
        errors++;
        $display("FAIL hold i=%0d got rdy=%b cke=%b odt=%b cmd=%b expected 1 1 0 0111",
                 i, ready, cke, ODT, {cs_bar, ras_bar, cas_bar, we_bar});
      end
      checks++;
    end
    chk("hold_cmd_count", cap.size(), 11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ddr2_init_engine.md
Name: ddr2_init_engine

Overview:
- Power-up initialization sequencer for the DDR2 SDRAM controller; sits upstream of the processing logic.
- Drives CKE and the DRAM command/address bus through the JEDEC DDR2 init sequence, then asserts ready.
- The processing logic leaves its init state on ready and takes ownership of the command bus.
- Once ready is high, the engine holds NOP/inactive outputs; the top-level mux selects the processing logic from then on.

Parameters:
- BL, 3'b011, burst length field for MRS (8)
- BT, 1'b0, burst type for MRS (sequential)
- CL, 3'b011, CAS latency for MRS (3)
- AL, 3'b001, additive latency for EMRS1 (1)
- WR, 3'b010, write recovery field for MRS (WR=3)
- T_INIT, 40000, cycles with CKE low after reset (200 us at 200 MHz)
- T_XPR, 80, cycles of NOP with CKE high before the first PRECHARGE ALL
- T_RP, 3, cycles per PRECHARGE ALL slot (command cycle included)
- T_MRD, 2, cycles per MRS/EMRS slot
- T_RFC, 21, cycles per REFRESH slot
- T_DLL, 200, cycles of NOP after the final MRS (DLL lock)

Ports:
- clk, input, 1, controller clock
- reset, input, 1, asynchronous, active-low reset
- ready, output, 1, init complete; sticky until reset
- busy, output, 1, high while the sequence is running (inverse of ready after reset)
- cke, output, 1, DRAM clock enable
- cs_bar, output, 1, DRAM chip select
- ras_bar, output, 1, DRAM RAS command strobe
- cas_bar, output, 1, DRAM CAS command strobe
- we_bar, output, 1, DRAM WE command strobe
- BA, output, 2, bank address
- A, output, 13, address / mode word
- ODT, output, 1, on-die termination; held 0
- init_state, output, 4, current state encoding (debug)

Behaviour:
- All outputs are registered on posedge clk.
- Command encodings {cs_bar,ras_bar,cas_bar,we_bar}: NOP 0111, PRE 0010, REF 0001, LMR 0000.
- Reset asserted (reset=0), asynchronously:
  - state = S_CKE_WAIT, counter = 0, cke = 0, command = NOP, BA = 0, A = 0, ODT = 0, ready = 0, busy = 1.
  - Reset mid-sequence aborts immediately, and the sequence restarts from S_CKE_WAIT on release.
- Slot model:
  - Each command state drives its command for exactly 1 cycle, then NOP for (slot-1) cycles.
  - The counter is 16 bits, clears on every state change, and the next state is entered when counter == slot-1.
  - A/BA stay valid during the command cycle; they return to 0 on NOP cycles.
- State sequence and slot lengths:
  - S_CKE_WAIT (T_INIT, cke=0, NOP)
  - S_XPR (T_XPR, cke=1 from this state onward, NOP)
  - S_PRE1 (T_RP; PRE with A[10]=1, BA=00)
  - S_EMRS2 (T_MRD; BA=10, A=0)
  - S_EMRS3 (T_MRD; BA=11, A=0)
  - S_EMRS1_DLL (T_MRD; BA=01, A=EMRS1 word with OCD=000)
  - S_MRS_RST (T_MRD; BA=00, A=MRS word with A[8]=1)
  - S_PRE2 (T_RP)
  - S_REF1 (T_RFC)
  - S_REF2 (T_RFC)
  - S_MRS (T_MRD; A[8]=0)
  - S_DLL_WAIT (T_DLL, NOP)
  - S_OCD_DEF (T_MRD; EMRS1 with OCD=111)
  - S_OCD_EXIT (T_MRD; EMRS1 with OCD=000)
  - S_DONE
- MRS word: A[12]=0, A[11:9]=WR, A[8]=DLL reset, A[7]=0, A[6:4]=CL, A[3]=BT, A[2:0]=BL.
- EMRS1 word:
  - A[0]=0 (DLL enable), A[1]=0 (full drive).
  - RTT 75 ohm: A[6]=0, A[2]=1.
  - A[5:3]=AL, A[9:7]=OCD, A[12:10]=000.
- S_DONE: ready=1, busy=0, cke=1, NOP, A=0, BA=0; holds until reset.
- Total latency from the first posedge after reset release to ready=1 is T_INIT+T_XPR+2*T_RP+7*T_MRD+2*T_RFC+T_DLL cycles (40342 at defaults).
- init_state encoding: S_CKE_WAIT=0 through S_DONE=14, in the order listed.
- Any slot parameter of 0 or 1 yields a 1-cycle slot (command, no NOP gap).

Optional Feature:
- Macro: DDR2_INIT_FAST_SIM_EN.
- Defined: T_INIT and T_DLL are overridden to 16 cycles each (total 174 cycles at the other defaults); the command order is unchanged.
- Undefined: the parameters are used as given.

Test Plan:
- Reset low for 3 cycles, then release: cke=0 and NOP for exactly T_INIT cycles, cke=1 on cycle T_INIT+1, and ready rises exactly 40342 cycles after release.
- Monitor the command bus: exactly 2 PRE (A[10]=1), 2 REF, and 7 LMR, in the listed order, with BA sequence 00,10,11,01,00,00(PRE),00,01,01.
- Check mode words at defaults:
  - MRS_RST: A = 13'h0533.
  - MRS: A = 13'h0433.
  - EMRS1_DLL: A = 13'h000C.
  - OCD_DEF: A = 13'h038C.
- Assert reset mid-S_REF1: cke=0, ready=0, NOP, and init_state=0 on the same edge without waiting for a clock; full sequence rerun after release.
- With DDR2_INIT_FAST_SIM_EN defined: ready rises exactly 174 cycles after release; DLL wait is 16 cycles.
- After ready: hold for 1000 cycles; ready stays 1, command stays NOP, cke stays 1, and ODT stays 0 throughout.
